stepgen_multi: RTL

STEPGEN_MULTI -- requirements
Module: stepgen_multi

---
 rtl/stepgen_multi.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/stepgen_multi.sv
// Multi-channel step/direction pulse generator with a Wishbone register port.
// Each channel has its own IDLE/SETUP/RUN sequencer, its own timing registers
// and its own done flag. irq is the registered OR of all done flags.
module stepgen_multi #(
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 16,
  parameter int DIR_SETUP = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                wb_cyc,
  input  logic                wb_stb,
  input  logic                wb_we,
  input  logic [3:0]          wb_sel,
  input  logic [7:0]          wb_adr,
  input  logic [31:0]         wb_dat_w,
  output logic [31:0]         wb_dat_r,
  output logic                wb_ack,
  output logic [CHANNELS-1:0] step,
  output logic [CHANNELS-1:0] dir,
  output logic                irq
);

  localparam int PW = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

  // Period length actually used: at least PULSE+1 so there is a low phase, and at least 2.
  function automatic logic [PW-1:0] calc_period(input logic [CNT_W-1:0] per,
                                                input logic [CNT_W-1:0] pul);
    logic [PW-1:0] p;
    p = {1'b0, per};
    if (({1'b0, pul} + PW'(1)) > p) p = {1'b0, pul} + PW'(1);
    if (p < PW'(2)) p = PW'(2);
    return p;
  endfunction

  // High time actually used: a zero PULSE still produces a one-clock pulse.
  function automatic logic [CNT_W-1:0] calc_high(input logic [CNT_W-1:0] pul);
    return (pul == '0) ? CNT_W'(1) : pul;
  endfunction

  state_t              r_state [CHANNELS];
  logic [PW-1:0]       r_ph    [CHANNELS];
  logic [PW-1:0]       r_p     [CHANNELS];
  logic [CNT_W-1:0]    r_h     [CHANNELS];
  logic [CNT_W-1:0]    r_rem   [CHANNELS];
  logic [CNT_W-1:0]    r_period[CHANNELS];
  logic [CNT_W-1:0]    r_pulse [CHANNELS];
  logic [CHANNELS-1:0] r_dir;
  logic [CHANNELS-1:0] r_done;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic                r_irq;

  state_t              w_state_nxt [CHANNELS];
  logic [PW-1:0]       w_ph_nxt    [CHANNELS];
  logic [PW-1:0]       w_p_nxt     [CHANNELS];
  logic [CNT_W-1:0]    w_h_nxt     [CHANNELS];
  logic [CNT_W-1:0]    w_rem_nxt   [CHANNELS];
  logic [CNT_W-1:0]    w_period_nxt[CHANNELS];
  logic [CNT_W-1:0]    w_pulse_nxt [CHANNELS];
  logic [CHANNELS-1:0] w_dir_nxt;
  logic [CHANNELS-1:0] w_done_nxt;
  logic [CHANNELS-1:0] w_hit;

  logic                w_req;
  logic                w_wr;
  logic [5:0]          w_ch;
  logic [1:0]          w_reg;
  logic [CNT_W-1:0]    w_cnt;
  logic [31:0]         w_dat_rd;
  logic                w_unused;

  // A request is accepted only when no ack is pending, so acks never come back-to-back.
  assign w_req    = wb_cyc & wb_stb & ~r_ack;
  assign w_wr     = w_req & wb_we;
  assign w_ch     = wb_adr[7:2];
  assign w_reg    = wb_adr[1:0];
  assign w_cnt    = wb_dat_w[CNT_W-1:0];
  assign w_unused = ^{wb_sel, wb_dat_w};

  assign wb_ack   = r_ack;
  assign wb_dat_r = r_dat;
  assign dir      = r_dir;
  assign irq      = r_irq;

  // Per-channel write decode; addresses of channels beyond CHANNELS hit nothing.
  always_comb begin
    w_hit = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_hit[c] = w_wr && (w_ch == 6'(c));
    end
  end

  // Read data mux; unimplemented bits and absent channels read as zero.
  always_comb begin
    w_dat_rd = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_ch == 6'(c)) begin
        case (w_reg)
          2'd0:    w_dat_rd = 32'(r_period[c]);
          2'd1:    w_dat_rd = 32'(r_pulse[c]);
          2'd2:    w_dat_rd = 32'(r_rem[c]);
          default: w_dat_rd = {30'b0, r_done[c], r_state[c] != IDLE};
        endcase
      end
    end
  end

  // Step pads decode straight from the sequencer registers.
  always_comb begin
    step = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      step[c] = (r_state[c] == RUN) && (r_ph[c] < {1'b0, r_h[c]});
    end
  end

  // Next-state logic for every channel; abort is applied last so it overrides completion.
  always_comb begin
    w_dir_nxt  = r_dir;
    w_done_nxt = r_done;
    for (int c = 0; c < CHANNELS; c++) begin
      w_state_nxt[c]  = r_state[c];
      w_ph_nxt[c]     = r_ph[c];
      w_p_nxt[c]      = r_p[c];
      w_h_nxt[c]      = r_h[c];
      w_rem_nxt[c]    = r_rem[c];
      w_period_nxt[c] = r_period[c];
      w_pulse_nxt[c]  = r_pulse[c];

      if (w_hit[c] && w_reg == 2'd0) w_period_nxt[c] = w_cnt;
      if (w_hit[c] && w_reg == 2'd1) w_pulse_nxt[c]  = w_cnt;
      // Clear first so a completion in the same cycle wins.
      if (w_hit[c] && w_reg == 2'd3 && wb_dat_w[1]) w_done_nxt[c] = 1'b0;

      case (r_state[c])
        IDLE: begin
          if (w_hit[c] && w_reg == 2'd2 && w_cnt != '0) begin
            w_state_nxt[c] = SETUP;
            w_ph_nxt[c]    = '0;
            w_rem_nxt[c]   = w_cnt;
            w_dir_nxt[c]   = wb_dat_w[31];
            w_done_nxt[c]  = 1'b0;
          end
        end
        SETUP: begin
          if (r_ph[c] == PW'(DIR_SETUP - 1)) begin
            w_state_nxt[c] = RUN;
            w_ph_nxt[c]    = '0;
            w_p_nxt[c]     = calc_period(r_period[c], r_pulse[c]);
            w_h_nxt[c]     = calc_high(r_pulse[c]);
          end else begin
            w_ph_nxt[c] = r_ph[c] + PW'(1);
          end
        end
        RUN: begin
          if (r_ph[c] == r_p[c] - PW'(1)) begin
            w_rem_nxt[c] = r_rem[c] - CNT_W'(1);
            w_ph_nxt[c]  = '0;
            if (r_rem[c] == CNT_W'(1)) begin
              w_state_nxt[c] = IDLE;
              w_done_nxt[c]  = 1'b1;
            end else begin
              w_p_nxt[c] = calc_period(r_period[c], r_pulse[c]);
              w_h_nxt[c] = calc_high(r_pulse[c]);
            end
          end else begin
            w_ph_nxt[c] = r_ph[c] + PW'(1);
          end
        end
        default: w_state_nxt[c] = IDLE;
      endcase

      if (w_hit[c] && w_reg == 2'd3 && wb_dat_w[0]) begin
        w_state_nxt[c] = IDLE;
        w_ph_nxt[c]    = '0;
        w_rem_nxt[c]   = '0;
        w_done_nxt[c]  = wb_dat_w[1] ? 1'b0 : r_done[c];
      end
    end
  end

  // State, timing and bus registers; reset clears everything.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c]  <= IDLE;
        r_ph[c]     <= '0;
        r_p[c]      <= '0;
        r_h[c]      <= '0;
        r_rem[c]    <= '0;
        r_period[c] <= '0;
        r_pulse[c]  <= '0;
      end
      r_dir  <= '0;
      r_done <= '0;
      r_ack  <= 1'b0;
      r_dat  <= '0;
      r_irq  <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_state[c]  <= w_state_nxt[c];
        r_ph[c]     <= w_ph_nxt[c];
        r_p[c]      <= w_p_nxt[c];
        r_h[c]      <= w_h_nxt[c];
        r_rem[c]    <= w_rem_nxt[c];
        r_period[c] <= w_period_nxt[c];
        r_pulse[c]  <= w_pulse_nxt[c];
      end
      r_dir <= w_dir_nxt;
      r_done <= w_done_nxt;
      r_ack <= w_req;
      if (w_req && !wb_we) r_dat <= w_dat_rd;
      r_irq <= |r_done;
    end
  end

endmodule
